// File: rtl/fetch_stage_pkg.sv
// Shared MIPS pipeline constants and the fetch controller state type.
// Imported by the fetch controller FSM and the fetch stage top.
package fetch_stage_pkg;

    localparam logic [31:0] NO_OP = 32'h0000_0000;

    localparam logic [5:0] OP_ALU = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch controller: state register, next-state logic and the imem request strobe.
// Any transaction left outstanding by a taken branch is finished in DRAIN.
module fetch_ctrl_fsm
    import fetch_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ack,
    input  logic         stall,
    input  logic         branch_taken,
    output fetch_state_t state,
    output logic         req
);

    fetch_state_t next_state;

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples values from before the clock edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        case (state)
            IDLE: begin
                next_state = RUN;
            end
            RUN: begin
                req = 1'b1;
                if (stall) begin
                    if (ack) begin
                        next_state = HOLD;
                    end
                end else if (branch_taken && !ack) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                // The stale request cannot be withdrawn, so keep it up until acked.
                req = 1'b1;
                if (ack) begin
                    next_state = RUN;
                end
            end
            HOLD: begin
                if (!stall) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, fetches over req/ack,
// and feeds IFIDIR/IFIDPC to decode with stall, squash and branch redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [31:0]       branchPCOffset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       IFIDIR,
    output logic [ADDR_W-1:0] IFIDPC,
    output logic              fetch_busy
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] stale_addr;
    logic [31:0]       hold_ir;
    logic [ADDR_W-1:0] hold_pc;
    logic [ADDR_W-1:0] branch_target;

    fetch_ctrl_fsm u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .ack          (imem_ack),
        .stall        (stall),
        .branch_taken (branchTaken),
        .state        (state),
        .req          (imem_req)
    );

    // Offset is sign-extended so a wider PC still branches backwards correctly.
    assign branch_target = IFIDPC + WORD_BYTES + ADDR_W'(signed'(branchPCOffset));

    always_comb begin
        imem_addr  = (state == DRAIN) ? stale_addr : pc;
        fetch_busy = (state == DRAIN) || (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
            hold_ir    <= NO_OP;
            hold_pc    <= '0;
            IFIDIR     <= NO_OP;
            IFIDPC     <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        // Park a word that lands during a stall; decode cannot take it yet.
                        if (imem_ack) begin
                            hold_ir <= imem_rdata;
                            hold_pc <= pc;
                            pc      <= pc + WORD_BYTES;
                        end
                    end else if (branchTaken) begin
                        IFIDIR <= NO_OP;
                        pc     <= branch_target;
                        if (!imem_ack) begin
                            stale_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        IFIDIR <= imem_rdata;
                        IFIDPC <= pc;
                        pc     <= pc + WORD_BYTES;
                    end else begin
                        IFIDIR <= NO_OP;
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        IFIDIR <= NO_OP;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        IFIDIR <= hold_ir;
                        IFIDPC <= hold_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
